// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-enabled data memory.
package dmem_pkg;

  // Controller state: zeroing sweep after reset, then normal service.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_e;

  // One response slot travelling down the latency pipe.
  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } dmem_rsp_t;

  // Word-index width for a given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Replace the enabled byte lanes of old_word with the matching lanes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  byteen);
    logic [31:0] lane_mask;
    lane_mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
    return (old_word & ~lane_mask) | (wdata & lane_mask);
  endfunction

endpackage

// File: rtl/dmem_rsp_pipe.sv
// Fixed-depth shift register that delays response records by READ_LAT cycles.
module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  dmem_rsp_t rsp_in,
  output dmem_rsp_t rsp_out
);

  dmem_rsp_t stage [READ_LAT];

  // Shift responses one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= rsp_in;
      for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign rsp_out = stage[READ_LAT-1];

endmodule

// File: rtl/byteen_dmem.sv
// Byte-enabled data memory for the M-stage port: clear sweep after reset,
// windowed access, READ_LAT-cycle responses and a one-cycle store trace.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready depends only on the FSM state, never on
// req_valid. Every transfer produces exactly one rsp_valid pulse, in order.
module byteen_dmem
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        busy,
  output logic [0:0]  dbg_state
);

  localparam int             AW       = idx_width(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

  dmem_state_e   state;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [29:0]   off_word;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          acc;
  logic          is_read;
  logic          wr_ok;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  dmem_rsp_t     rsp_in;
  dmem_rsp_t     rsp_out;
  logic          unused_addr_bits;

  // Byte lanes within the word are ignored; BASE_ADDR is word-aligned, so the
  // word offset is a plain 30-bit subtraction that wraps below the base.
  assign unused_addr_bits = ^req_addr[1:0];
  assign off_word = req_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = ({2'b00, off_word} < 32'(DEPTH_WORDS));
  assign idx      = off_word[AW-1:0];

  assign req_ready = (state == ST_RUN);
  assign busy      = (state == ST_CLEAR);
  assign dbg_state = state;

  assign acc      = req_valid & req_ready;
  assign is_read  = (req_byteen == 4'b0000);
  assign wr_ok    = acc & ~is_read & in_range;
  assign old_word = mem[idx];
  assign merged   = merge_bytes(old_word, req_wdata, req_byteen);

  // Response record formed at the accept edge; writes and errors carry 0 data.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = acc;
    rsp_in.err   = acc & ~in_range;
    rsp_in.rdata = (acc & is_read & in_range) ? old_word : 32'h0;
  end

  // Sweep clr_idx across the array once, then hand over to normal service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == LAST_IDX) state <= ST_RUN;
    end
  end

  // Array write port: zero during the sweep, merged store word otherwise.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[clr_idx] <= '0;
    else if (wr_ok)        mem[idx]     <= merged;
  end

  // One-cycle trace of each committed store, showing the word after the merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_addr  <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= wr_ok;
      if (wr_ok) begin
        trace_pc   <= req_pc;
        trace_addr <= {req_addr[31:2], 2'b00};
        trace_data <= merged;
      end
    end
  end

  dmem_rsp_pipe #(.READ_LAT(READ_LAT)) u_rsp_pipe (
    .clk     (clk),
    .reset   (reset),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign rsp_valid = rsp_out.valid;
  assign rsp_rdata = rsp_out.rdata;
  assign rsp_err   = rsp_out.err;

endmodule

// File: tb/tb_byteen_dmem.sv
// Directed plus randomized bench for byteen_dmem with a word-array reference model.
module tb_byteen_dmem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LAT   = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_byteen;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        busy;
  logic [0:0]  dbg_state;

  byteen_dmem #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .READ_LAT    (LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_byteen  (req_byteen),
    .req_wdata   (req_wdata),
    .req_pc      (req_pc),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [32:0] exp_q[$];       // {err, rdata}
  int          exp_due_q[$];   // cycle count at which the response is sampled
  logic [95:0] exp_tr_q[$];    // {pc, addr, data}
  int          exp_tr_due_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic drop_expected();
    exp_q.delete();
    exp_due_q.delete();
    exp_tr_q.delete();
    exp_tr_due_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Present one request for one cycle; expectations come from the word model.
  task automatic issue(input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] pc);
    logic [31:0] off;
    logic [31:0] word;
    logic [31:0] exp_rdata;
    bit          hit;
    int          w;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_byteen = be;
    req_wdata  = wd;
    req_pc     = pc;
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    off = addr - BASE;
    hit = ((off / 4) < DEPTH);
    w   = hit ? int'(off / 4) : 0;
    word = ref_mem[w];
    exp_rdata = 32'h0;
    if (hit && be == 4'b0000) exp_rdata = word;
    if (hit && be != 4'b0000) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
    end
    @(posedge clk);
    #1;
    exp_q.push_back({~hit, exp_rdata});
    exp_due_q.push_back(cyc + LAT - 1);
    if (hit && be != 4'b0000) begin
      ref_mem[w] = word;
      exp_tr_q.push_back({pc, addr & 32'hFFFF_FFFC, word});
      exp_tr_due_q.push_back(cyc);
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Count edges from reset release until busy drops; must equal DEPTH.
  task automatic wait_sweep(input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    chk({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
    do begin
      @(posedge clk);
      #1;
      n++;
      if (busy && req_ready) bad++;
    end while (busy && n < 200);
    chk({tag, "_sweep_cycles"}, 32'(n), 32'(DEPTH));
    chk({tag, "_ready_while_busy"}, 32'(bad), 32'd0);
    chk({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    model_clear();
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        int          due;
        e   = exp_q.pop_front();
        due = exp_due_q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(due));
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
      end
    end
    if (trace_valid) begin
      if (exp_tr_q.size() == 0) begin
        chk("trace_unexpected", 32'd1, 32'd0);
      end else begin
        logic [95:0] t;
        int          due;
        t   = exp_tr_q.pop_front();
        due = exp_tr_due_q.pop_front();
        chk("trace_cycle", 32'(cyc), 32'(due));
        chk("trace_pc", trace_pc, t[95:64]);
        chk("trace_addr", trace_addr, t[63:32]);
        chk("trace_data", trace_data, t[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [31:0] a;
    logic [3:0]  be;
    int          waited;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_byteen = '0;
    req_wdata  = '0;
    req_pc     = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_trace_valid", {31'b0, trace_valid}, 32'd0);
    chk("rst_trace_pc", trace_pc, 32'd0);
    chk("rst_trace_addr", trace_addr, 32'd0);
    chk("rst_trace_data", trace_data, 32'd0);

    // Clear sweep and readiness
    @(negedge clk);
    reset = 1'b0;
    wait_sweep("sweep1");
    for (int i = 0; i < DEPTH; i++) issue(BASE + 32'(4 * i), 4'b0000, 32'h0, 32'h200 + 32'(4 * i));

    // Partial store merge, then read back
    issue(BASE + 32'h10, 4'b1111, 32'h1122_3344, 32'h0000_0100);
    issue(BASE + 32'h10, 4'b0101, 32'hAABB_CCDD, 32'h0000_0104);
    issue(BASE + 32'h10, 4'b0000, 32'h0, 32'h0000_0108);
    idle(3);

    // Back-to-back reads, pipelined latency
    issue(BASE + 32'h0, 4'b0000, 32'h0, 32'h300);
    issue(BASE + 32'h4, 4'b0000, 32'h0, 32'h304);
    issue(BASE + 32'h8, 4'b0000, 32'h0, 32'h308);
    idle(3);

    // Window edges
    issue(BASE + 32'h3C, 4'b1111, 32'hCAFE_F00D, 32'h400);
    issue(BASE - 32'h4, 4'b1111, 32'hDEAD_BEEF, 32'h404);
    issue(BASE + 32'h40, 4'b0000, 32'h0, 32'h408);
    issue(BASE + 32'h3F, 4'b0000, 32'h0, 32'h40C);
    issue(32'h0000_0000, 4'b0011, 32'h1234_5678, 32'h410);
    idle(3);

    // Randomized mix around and across the window
    for (int n = 0; n < 80; n++) begin
      k  = $urandom_range(0, 21);
      a  = BASE - 32'h8 + 32'(4 * k) + 32'($urandom_range(0, 3));
      be = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      issue(a, be, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    // Reset with a read in flight: its response must never appear
    issue(BASE + 32'h10, 4'b0000, 32'h0, 32'h500);
    reset = 1'b1;
    drop_expected();
    idle(3);
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_sweep_busy", {31'b0, busy}, 32'd1);
    // Reset again mid-sweep; the sweep restarts from word 0
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    reset = 1'b0;
    wait_sweep("sweep2");
    for (int i = 0; i < DEPTH; i += 5) issue(BASE + 32'(4 * i), 4'b0000, 32'h0, 32'h600);

    // Drain outstanding expectations
    waited = 0;
    while ((exp_q.size() != 0 || exp_tr_q.size() != 0) && waited < 50) begin
      idle(1);
      waited++;
    end
    chk("rsp_drained", 32'(exp_q.size()), 32'd0);
    chk("trace_drained", 32'(exp_tr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
